adc_serial_capture: RTL and testbench

Parametrised capture engine for serial SAR ADCs with leading-zero frames, such as 12-bit converters framed as 4 zeros + 12 data bits. It generates cs_n and sclk, shifts in CHANNELS parallel serial data lines, and checks the leading-zero bits. Results can optionally be averaged over 2^AVG_LOG2 frames. The block sits between the ADC pins and the display/register path and presents a valid-strobed, packed sample word.

---
 rtl/adc_serial_capture.sv | 213 +++++++++++++++++++++
 tb/tb_adc_serial_capture.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
// Serial SAR ADC capture engine: generates cs_n/sclk, shifts in CHANNELS data lines,
// checks the leading-zero bits and optionally averages 2^AVG_LOG2 frames per output.

module adc_serial_capture_lane #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic              bit_i,
    input  logic              done_i,
    input  logic              emit_i,
    output logic [DATA_W-1:0] data_o
);
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0] sh_q, sh_d, dout_q;
    logic [ACC_W-1:0]  acc_q, sum;

    // Zero bits shift through too; only the last DATA_W bits survive to frame end.
    assign sh_d   = (sh_q << 1) | DATA_W'(bit_i);
    assign sum    = acc_q + ACC_W'(sh_q);
    assign data_o = dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            if (shift_en_i) sh_q <= sh_d;
            if (done_i) begin
                if (emit_i) begin
                    dout_q <= DATA_W'(sum >> AVG_LOG2);
                    acc_q  <= '0;
                end else begin
                    acc_q  <= sum;
                end
            end
        end
    end
endmodule

module adc_serial_capture #(
    parameter int DATA_W    = 12,
    parameter int ZERO_BITS = 4,
    parameter int CHANNELS  = 2,
    parameter int SCLK_DIV  = 4,
    parameter int QUIET_CYC = 8,
    parameter int AVG_LOG2  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [CHANNELS-1:0]          data_in,
    output logic                         cs_n,
    output logic                         sclk,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic                         valid,
    output logic                         zeros_err,
    output logic                         busy
);
    localparam int FRAME_W = ZERO_BITS + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int DIV_W   = $clog2(SCLK_DIV + 1);
    localparam int QW      = $clog2(QUIET_CYC + 1);
    localparam int FCW     = AVG_LOG2 + 1;
    localparam int NFRM    = 1 << AVG_LOG2;

    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

    state_t           state_q, state_d;
    logic             cs_n_q, cs_n_d, sclk_q, sclk_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic             ferr_q, ferr_d, serr_q, serr_d;
    logic             valid_q, valid_d, zerr_q, zerr_d;
    logic             shift_en, done, emit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            quiet_q <= '0;
            fcnt_q  <= '0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
            valid_q <= 1'b0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            quiet_q <= quiet_d;
            fcnt_q  <= fcnt_d;
            ferr_q  <= ferr_d;
            serr_q  <= serr_d;
            valid_q <= valid_d;
            zerr_q  <= zerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        quiet_d  = quiet_q;
        fcnt_d   = fcnt_q;
        ferr_d   = ferr_q;
        serr_d   = serr_q;
        valid_d  = 1'b0;
        zerr_d   = zerr_q;
        shift_en = 1'b0;
        done     = 1'b0;
        emit     = (fcnt_q == FCW'(NFRM - 1));

        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = CONV;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
                end
            end
            CONV: begin
                if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d   = 1'b1;
                        shift_en = 1'b1;
                        bit_d    = bit_q + 1'b1;
                        if (bit_q < BIT_W'(ZERO_BITS) && |data_in) ferr_d = 1'b1;
                    end else if (bit_q == BIT_W'(FRAME_W)) begin
                        // Last high half-period served in full; sclk simply stays high.
                        state_d = QUIET;
                        cs_n_d  = 1'b1;
                        quiet_d = '0;
                        done    = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            QUIET: begin
                if (quiet_q == QW'(QUIET_CYC - 1)) begin
                    if (continuous) begin
                        state_d = CONV;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        div_d   = '0;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Error state and frame count persist across IDLE so a partial set resumes.
        if (done) begin
            if (emit) begin
                fcnt_d  = '0;
                valid_d = 1'b1;
                zerr_d  = serr_q | ferr_q;
                serr_d  = 1'b0;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
                serr_d  = serr_q | ferr_q;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        adc_serial_capture_lane #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .shift_en_i (shift_en),
            .bit_i      (data_in[c]),
            .done_i     (done),
            .emit_i     (emit),
            .data_o     (data_out[c*DATA_W +: DATA_W])
        );
    end

    assign cs_n      = cs_n_q;
    assign sclk      = sclk_q;
    assign valid     = valid_q;
    assign zeros_err = zerr_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_adc_serial_capture.sv
// Randomised scoreboard bench: a raw (AVG_LOG2=0) and an averaging (AVG_LOG2=2) instance,
// each fed by a behavioural ADC model that also predicts the expected results.

module tb_adc_serial_capture;
    localparam int DW = 12, ZB = 4, CH = 2, FW = ZB + DW, SD = 2, QC = 4;

    logic clk = 1'b0;
    logic rst;
    logic r_start, r_cont, a_start, a_cont;
    logic [CH-1:0] r_din = '0, a_din = '0;
    logic r_csn, r_sclk, r_valid, r_zerr, r_busy;
    logic a_csn, a_sclk, a_valid, a_zerr, a_busy;
    logic [CH*DW-1:0] r_dout, a_dout;

    always #5 clk = ~clk;

    adc_serial_capture #(.DATA_W(DW), .ZERO_BITS(ZB), .CHANNELS(CH), .SCLK_DIV(SD),
                         .QUIET_CYC(QC), .AVG_LOG2(0)) u_raw (
        .clk(clk), .rst(rst), .start(r_start), .continuous(r_cont), .data_in(r_din),
        .cs_n(r_csn), .sclk(r_sclk), .data_out(r_dout), .valid(r_valid),
        .zeros_err(r_zerr), .busy(r_busy));

    adc_serial_capture #(.DATA_W(DW), .ZERO_BITS(ZB), .CHANNELS(CH), .SCLK_DIV(SD),
                         .QUIET_CYC(QC), .AVG_LOG2(2)) u_avg (
        .clk(clk), .rst(rst), .start(a_start), .continuous(a_cont), .data_in(a_din),
        .cs_n(a_csn), .sclk(a_sclk), .data_out(a_dout), .valid(a_valid),
        .zeros_err(a_zerr), .busy(a_busy));

    typedef struct packed {
        logic [CH-1:0][DW-1:0] d;
        logic [CH-1:0][ZB-1:0] z;
    } frame_t;
    typedef struct packed {
        logic [CH*DW-1:0] d;
        logic             e;
    } exp_t;

    frame_t r_stim[$], a_stim[$];
    exp_t   r_exp[$], a_exp[$];
    int checks = 0, fails = 0;
    int r_nf = 0, a_nf = 0, r_vcnt = 0, a_vcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic frame_t mk_frame(input int d0, input int d1, input int z0, input int z1);
        frame_t f;
        f.d[0] = DW'(d0); f.d[1] = DW'(d1);
        f.z[0] = ZB'(z0); f.z[1] = ZB'(z1);
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f = mk_frame($urandom_range(0, 4095), $urandom_range(0, 4095), 0, 0);
        if ($urandom_range(0, 5) == 0) f.z[$urandom_range(0, 1)] = ZB'($urandom_range(1, 15));
        return f;
    endfunction

    // Bit idx of the frame as it appears on the wire, MSB first, zeros leading.
    function automatic logic [CH-1:0] frame_bits(input frame_t f, input int idx);
        logic [FW-1:0] w;
        logic [CH-1:0] b;
        b = '0;
        for (int c = 0; c < CH; c++) begin
            w = {f.z[c], f.d[c]};
            if (idx < FW) b[c] = w[FW-1-idx];
        end
        return b;
    endfunction

    // Raw ADC model: new frame on cs_n fall, next bit after each sclk fall.
    int     r_idx = 0;
    frame_t r_cur = '0;
    exp_t   r_e;
    logic   r_pcs = 1'b1, r_psk = 1'b1;
    always @(posedge clk) begin
        #1;
        if (r_pcs && !r_csn) begin
            r_cur = (r_stim.size() != 0) ? r_stim.pop_front() : rand_frame();
            r_e.d = r_cur.d;
            r_e.e = |r_cur.z;
            r_exp.push_back(r_e);
            r_idx = 0;
            r_nf++;
        end else if (!r_csn && r_psk && !r_sclk) begin
            r_idx++;
        end
        r_pcs = r_csn;
        r_psk = r_sclk;
        r_din = frame_bits(r_cur, r_idx);
    end

    // Averaging ADC model: mean of each group of 4 frames, truncated.
    int     a_idx = 0, a_cnt = 0;
    int     a_sum[CH] = '{0, 0};
    logic   a_err = 1'b0;
    frame_t a_cur = '0;
    exp_t   a_e;
    logic   a_pcs = 1'b1, a_psk = 1'b1;
    always @(posedge clk) begin
        #1;
        if (a_pcs && !a_csn) begin
            a_cur = (a_stim.size() != 0) ? a_stim.pop_front() : rand_frame();
            for (int c = 0; c < CH; c++) a_sum[c] += int'(a_cur.d[c]);
            a_err = a_err | (|a_cur.z);
            a_cnt++;
            if (a_cnt == 4) begin
                for (int c = 0; c < CH; c++) a_e.d[c*DW +: DW] = DW'(a_sum[c] / 4);
                a_e.e = a_err;
                a_exp.push_back(a_e);
                a_cnt = 0; a_err = 1'b0;
                for (int c = 0; c < CH; c++) a_sum[c] = 0;
            end
            a_idx = 0;
            a_nf++;
        end else if (!a_csn && a_psk && !a_sclk) begin
            a_idx++;
        end
        a_pcs = a_csn;
        a_psk = a_sclk;
        a_din = frame_bits(a_cur, a_idx);
    end

    // Scoreboard monitors.
    exp_t r_got, a_got;
    always @(negedge clk) begin
        if (!rst && r_valid) begin
            r_vcnt++;
            if (r_exp.size() == 0) begin
                checks++; fails++;
                $display("FAIL raw_unexpected_valid actual=valid required=none");
            end else begin
                r_got = r_exp.pop_front();
                check("raw_data", 64'(r_dout), 64'(r_got.d));
                check("raw_zerr", 64'(r_zerr), 64'(r_got.e));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && a_valid) begin
            a_vcnt++;
            if (a_exp.size() == 0) begin
                checks++; fails++;
                $display("FAIL avg_unexpected_valid actual=valid required=none");
            end else begin
                a_got = a_exp.pop_front();
                check("avg_data", 64'(a_dout), 64'(a_got.d));
                check("avg_zerr", 64'(a_zerr), 64'(a_got.e));
            end
        end
    end

    // Pin-timing monitor on the raw instance.
    int   lo_len = 0, hi_len = 0, rises = 0;
    logic m_pcs = 1'b1, m_psk = 1'b1;
    bit   in_frame = 1'b0, trk = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0; trk = 1'b0; m_pcs = 1'b1; m_psk = 1'b1;
        end else begin
            if (!r_csn) begin
                if (m_pcs) begin
                    if (trk) check("quiet_len", 64'(hi_len), 64'(QC));
                    trk = 1'b0; lo_len = 0; rises = 0; in_frame = 1'b1;
                end
                lo_len++;
                if (!m_psk && r_sclk) rises++;
            end else begin
                if (!m_pcs && in_frame) begin
                    check("cs_low_len", 64'(lo_len), 64'(FW * 2 * SD));
                    check("sclk_rises", 64'(rises), 64'(FW));
                    in_frame = 1'b0; trk = 1'b1; hi_len = 0;
                end
                if (trk) begin
                    check("sclk_idle_high", 64'(r_sclk), 64'd1);
                    if (r_busy) hi_len++;
                    else begin
                        check("busy_drop", 64'(hi_len), 64'(QC));
                        trk = 1'b0;
                    end
                end
            end
            m_pcs = r_csn;
            m_psk = r_sclk;
        end
    end

    task automatic pulse(input int which);
        @(negedge clk);
        if (which != 0) a_start = 1'b1; else r_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; r_start = 1'b0;
    endtask

    task automatic wait_idle(input int which);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (((which != 0) ? a_busy : r_busy) && n < 5000) begin
            @(negedge clk); n++;
        end
        if (n >= 5000) begin
            checks++; fails++;
            $display("FAIL idle_timeout dut=%0d actual=busy required=idle", which);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frames(input int which, input int target);
        int n;
        n = 0;
        while (((which != 0) ? a_nf : r_nf) < target && n < 5000) begin
            @(negedge clk); n++;
        end
        if (n >= 5000) begin
            checks++; fails++;
            $display("FAIL frame_timeout dut=%0d actual=%0d required=%0d", which,
                     (which != 0) ? a_nf : r_nf, target);
        end
    endtask

    int v0, n0, nw;
    initial begin
        rst = 1'b1;
        r_start = 1'b0; r_cont = 1'b0; a_start = 1'b0; a_cont = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(r_csn), 64'd1);
        check("rst_sclk", 64'(r_sclk), 64'd1);
        check("rst_dout", 64'(r_dout), 64'd0);
        check("rst_valid", 64'(r_valid), 64'd0);
        check("rst_zerr", 64'(r_zerr), 64'd0);
        check("rst_busy", 64'(r_busy), 64'd0);
        check("rst_avg_cs_n", 64'(a_csn), 64'd1);
        check("rst_avg_dout", 64'(a_dout), 64'd0);
        check("rst_avg_busy", 64'(a_busy), 64'd0);
        rst = 1'b0;

        // Single clean frame.
        r_stim.push_back(mk_frame('hA5C, 'h3F1, 0, 0));
        v0 = r_vcnt;
        pulse(0); wait_idle(0);
        check("t1_valids", 64'(r_vcnt - v0), 64'd1);
        check("t1_dout", 64'(r_dout), 64'h3F1A5C);
        check("t1_zerr", 64'(r_zerr), 64'd0);

        // Leading-zero violation on ch1, then a clean frame clears the flag.
        r_stim.push_back(mk_frame('h123, 'h456, 0, 'b0010));
        pulse(0); wait_idle(0);
        check("t2_dout", 64'(r_dout), 64'h456123);
        check("t2_zerr", 64'(r_zerr), 64'd1);
        r_stim.push_back(mk_frame('h7E1, 'h0B2, 0, 0));
        pulse(0); wait_idle(0);
        check("t2_clean_zerr", 64'(r_zerr), 64'd0);
        check("t2_clean_dout", 64'(r_dout), 64'h0B27E1);

        // start while busy is ignored.
        v0 = r_vcnt; n0 = r_nf;
        pulse(0);
        repeat (20) @(negedge clk);
        pulse(0);
        wait_idle(0);
        check("t6_valids", 64'(r_vcnt - v0), 64'd1);
        check("t6_frames", 64'(r_nf - n0), 64'd1);

        // Continuous for 3 frames, dropped mid-frame 3.
        v0 = r_vcnt; n0 = r_nf;
        r_cont = 1'b1;
        wait_frames(0, n0 + 3);
        repeat (20) @(negedge clk);
        r_cont = 1'b0;
        wait_idle(0);
        check("t4_valids", 64'(r_vcnt - v0), 64'd3);
        check("t4_busy", 64'(r_busy), 64'd0);

        // Reset at bit 7 aborts the frame.
        v0 = r_vcnt;
        pulse(0);
        nw = 0;
        while (!(r_idx == 7 && !r_csn) && nw < 2000) begin
            @(posedge clk); nw++;
        end
        if (nw >= 2000) begin
            checks++; fails++;
            $display("FAIL bit7_timeout actual=%0d required=7", r_idx);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_cs_n", 64'(r_csn), 64'd1);
        check("t5_sclk", 64'(r_sclk), 64'd1);
        check("t5_busy", 64'(r_busy), 64'd0);
        void'(r_exp.pop_back());
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_valid", 64'(r_vcnt - v0), 64'd0);
        check("t5_dout_cleared", 64'(r_dout), 64'd0);
        pulse(0); wait_idle(0);
        check("t5_after_valids", 64'(r_vcnt - v0), 64'd1);

        // Random single frames.
        repeat (6) begin
            pulse(0); wait_idle(0);
        end

        // Averaging: mean of 100,101,102,104 on ch0.
        v0 = a_vcnt; n0 = a_nf;
        a_stim.push_back(mk_frame(100, $urandom_range(0, 4095), 0, 0));
        a_stim.push_back(mk_frame(101, $urandom_range(0, 4095), 0, 0));
        a_stim.push_back(mk_frame(102, $urandom_range(0, 4095), 0, 0));
        a_stim.push_back(mk_frame(104, $urandom_range(0, 4095), 0, 0));
        a_cont = 1'b1;
        wait_frames(1, n0 + 4);
        a_cont = 1'b0;
        wait_idle(1);
        check("t3_valids", 64'(a_vcnt - v0), 64'd1);
        check("t3_ch0_mean", 64'(a_dout[DW-1:0]), 64'd101);

        // Full-scale average must not overflow.
        n0 = a_nf;
        repeat (4) a_stim.push_back(mk_frame('hFFF, 'hFFF, 0, 0));
        a_cont = 1'b1;
        wait_frames(1, n0 + 4);
        a_cont = 1'b0;
        wait_idle(1);
        check("t3_fullscale", 64'(a_dout), 64'hFFFFFF);
        check("t3_fullscale_zerr", 64'(a_zerr), 64'd0);

        // Partial set survives IDLE; error in frame 2 reported with the set.
        v0 = a_vcnt;
        a_stim.push_back(mk_frame(10, 20, 0, 0));
        a_stim.push_back(mk_frame(30, 40, 'b1000, 0));
        pulse(1); wait_idle(1);
        pulse(1); wait_idle(1);
        check("avg_partial_no_valid", 64'(a_vcnt - v0), 64'd0);
        a_stim.push_back(mk_frame(50, 60, 0, 0));
        a_stim.push_back(mk_frame(70, 80, 0, 0));
        pulse(1); wait_idle(1);
        pulse(1); wait_idle(1);
        check("avg_partial_valid", 64'(a_vcnt - v0), 64'd1);
        check("avg_partial_dout", 64'(a_dout), {40'd0, 12'd50, 12'd40});
        check("avg_partial_zerr", 64'(a_zerr), 64'd1);

        // Random continuous run of 8 frames.
        n0 = a_nf;
        a_cont = 1'b1;
        wait_frames(1, n0 + 8);
        a_cont = 1'b0;
        wait_idle(1);

        repeat (10) @(negedge clk);
        check("raw_queue_empty", 64'(r_exp.size()), 64'd0);
        check("avg_queue_empty", 64'(a_exp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
